// File: rtl/mul_sequencer_if.sv
// Decoder-side handshake bundle for the iterative multiplier: request, operands,
// flush, and the stall/done/result signals returned to the pipeline.
interface mul_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start_mul;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            mul_done;
    logic [XLEN-1:0] mul_result;

    modport master (
        output start_mul, funct3, rs1_val, rs2_val, flush,
        input  stall, busy, mul_done, mul_result
    );

    modport slave (
        input  start_mul, funct3, rs1_val, rs2_val, flush,
        output stall, busy, mul_done, mul_result
    );
endinterface

// File: rtl/mul_sequencer.sv
// Radix-2 shift-add multiplier for the RV32M MUL group; operands are reduced to
// magnitudes at start, the sign is reapplied to the full product on the last step.
module mul_sequencer #(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             reset,
    mul_sequencer_if.slave   bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   mcand;
    logic [XLEN-1:0]   mplier;
    logic              neg;
    logic [1:0]        op;
    logic [CW-1:0]     counter;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   result;

    logic              start_ok;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic              last;
    logic [2*XLEN-1:0] partial, acc_sum, prod;
    logic [XLEN-1:0]   prod_slice;

    always_comb begin
        start_ok   = bus.start_mul && !bus.funct3[2] && !bus.flush;
        // MULH: both signed; MULHSU: only rs1 signed; MUL/MULHU treated as unsigned.
        a_neg      = ((bus.funct3[1:0] == 2'b01) || (bus.funct3[1:0] == 2'b10)) && bus.rs1_val[XLEN-1];
        b_neg      = (bus.funct3[1:0] == 2'b01) && bus.rs2_val[XLEN-1];
        a_abs      = a_neg ? ('0 - bus.rs1_val) : bus.rs1_val;
        b_abs      = b_neg ? ('0 - bus.rs2_val) : bus.rs2_val;
        last       = (counter == CW'(XLEN - 1));
        partial    = mplier[0] ? ({{XLEN{1'b0}}, mcand} << counter) : '0;
        acc_sum    = acc + partial;
        prod       = neg ? ('0 - acc_sum) : acc_sum;
        prod_slice = (op == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = BUSY;
            BUSY:    if (last)     state_nxt = DONE;
            DONE:                  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
        if (bus.flush) state_nxt = IDLE;

        bus.stall      = !reset && !bus.flush &&
                         (((state == IDLE) && bus.start_mul && !bus.funct3[2]) || (state == BUSY));
        bus.busy       = (state != IDLE);
        bus.mul_done   = (state == DONE) && !bus.flush;
        bus.mul_result = result;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand   <= '0;
            mplier  <= '0;
            neg     <= 1'b0;
            op      <= 2'b00;
            counter <= '0;
            acc     <= '0;
            result  <= '0;
        end else if ((state == IDLE) && start_ok) begin
            mcand   <= a_abs;
            mplier  <= b_abs;
            neg     <= a_neg ^ b_neg;
            op      <= bus.funct3[1:0];
            counter <= '0;
            acc     <= '0;
        end else if ((state == BUSY) && !bus.flush) begin
            acc     <= acc_sum;
            mplier  <= mplier >> 1;
            counter <= counter + CW'(1);
            if (last) result <= prod_slice;
        end
    end
endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: vector table plus scoreboard queue,
// with hand-written flush, reset, back-to-back and illegal-funct3 sequences.
module tb_mul_sequencer;
    logic clk;
    logic reset;
    int   cyc;
    int   passed;
    int   total;
    logic [31:0] sb[$];

    mul_sequencer_if #(.XLEN(32)) bus ();

    mul_sequencer #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = ((f3[1:0] == 2'b01) || (f3[1:0] == 2'b10)) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (f3[1:0] == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (f3[1:0] == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
        int   n_stall;
        bit   seen;
        logic [31:0] want;
        @(negedge clk);
        bus.start_mul = 1'b1;
        bus.funct3    = f3;
        bus.rs1_val   = a;
        bus.rs2_val   = b;
        sb.push_back(exp);
        n_stall = 0;
        seen    = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            #1;
            if (bus.mul_done) begin
                seen = 1'b1;
                want = sb.pop_front();
                check({name, " result"}, bus.mul_result, want);
                check({name, " stall in done"}, {31'b0, bus.stall}, 32'd0);
            end else if (bus.stall) begin
                n_stall++;
            end
            @(negedge clk);
            if (c == 0) begin
                // Scramble inputs after the start cycle; the latched copies must be used.
                bus.start_mul = 1'b0;
                bus.rs1_val   = $urandom;
                bus.rs2_val   = $urandom;
                bus.funct3    = 3'($urandom_range(0, 3));
            end
        end
        if (!seen) begin
            check({name, " done timeout"}, 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        check({name, " stalled cycles"}, n_stall, 32'd33);
        #1;
        check({name, " busy after done"}, {31'b0, bus.busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, d1, pulses;
        logic [31:0] want;
        logic [31:0] ra, rb;
        logic [2:0]  rf;
        passed = 0;
        total  = 0;

        tbl[0] = '{3'b000, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
        tbl[1] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        tbl[2] = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
        tbl[3] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[4] = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        tbl[5] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tbl[6] = '{3'b011, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000};
        tbl[7] = '{3'b000, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1};
        tbl[8] = '{3'b010, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF};
        tbl[9] = '{3'b011, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001};

        // Reset with a pending request: everything must stay quiet.
        reset         = 1'b1;
        bus.start_mul = 1'b1;
        bus.funct3    = 3'b000;
        bus.rs1_val   = 32'd3;
        bus.rs2_val   = 32'd4;
        bus.flush     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset stall", {31'b0, bus.stall}, 32'd0);
        check("reset busy", {31'b0, bus.busy}, 32'd0);
        check("reset mul_done", {31'b0, bus.mul_done}, 32'd0);
        check("reset mul_result", bus.mul_result, 32'd0);
        bus.start_mul = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++)
            run_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            rf = 3'($urandom_range(0, 3));
            run_op(rf, ra, rb, model(rf, ra, rb), $sformatf("rnd%0d", i));
        end
        run_op(3'b000, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, "mul pre-flush");

        // Flush on BUSY cycle 10.
        @(negedge clk);
        bus.start_mul = 1'b1;
        bus.funct3    = 3'b000;
        bus.rs1_val   = 32'd3;
        bus.rs2_val   = 32'd5;
        @(negedge clk);
        bus.start_mul = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check("busy before flush", {31'b0, bus.busy}, 32'd1);
        check("stall during flush", {31'b0, bus.stall}, 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check("busy after flush", {31'b0, bus.busy}, 32'd0);
        check("stall after flush", {31'b0, bus.stall}, 32'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (bus.mul_done) pulses++;
        end
        check("no done after flush", pulses, 32'd0);
        check("result kept after flush", bus.mul_result, 32'h0000_002A);

        // flush beats start_mul in IDLE.
        @(negedge clk);
        bus.start_mul = 1'b1;
        bus.flush     = 1'b1;
        #1;
        check("flush vs start stall", {31'b0, bus.stall}, 32'd0);
        @(negedge clk);
        bus.start_mul = 1'b0;
        bus.flush     = 1'b0;
        #1;
        check("flush vs start busy", {31'b0, bus.busy}, 32'd0);

        // Reset on BUSY cycle 5.
        @(negedge clk);
        bus.start_mul = 1'b1;
        bus.funct3    = 3'b011;
        bus.rs1_val   = 32'hFFFF_FFFF;
        bus.rs2_val   = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.start_mul = 1'b0;
        repeat (4) @(negedge clk);
        reset         = 1'b1;
        bus.start_mul = 1'b1;
        #1;
        check("midop reset stall", {31'b0, bus.stall}, 32'd0);
        check("midop reset busy", {31'b0, bus.busy}, 32'd0);
        check("midop reset mul_done", {31'b0, bus.mul_done}, 32'd0);
        check("midop reset mul_result", bus.mul_result, 32'd0);
        @(negedge clk);
        bus.start_mul = 1'b0;
        reset         = 1'b0;

        // start_mul held high across two multiplies.
        @(negedge clk);
        bus.start_mul = 1'b1;
        bus.funct3    = 3'b000;
        bus.rs1_val   = 32'd1000;
        bus.rs2_val   = 32'd1000;
        sb.push_back(32'd1_000_000);
        sb.push_back(32'd1_000_000);
        d0 = -1;
        d1 = -1;
        for (int c = 0; c < 150 && d1 < 0; c++) begin
            #1;
            if (d0 >= 0 && cyc == d0 + 1)
                check("b2b stall reasserts", {31'b0, bus.stall}, 32'd1);
            if (bus.mul_done) begin
                want = sb.pop_front();
                check("b2b result", bus.mul_result, want);
                if (d0 < 0) d0 = cyc;
                else begin
                    d1 = cyc;
                    bus.start_mul = 1'b0;
                end
            end
            @(negedge clk);
        end
        if (d1 < 0) begin
            check("b2b done timeout", 32'd0, 32'd1);
            sb.delete();
            bus.start_mul = 1'b0;
        end else begin
            check("b2b pulse spacing", d1 - d0, 32'd34);
        end
        #1;
        check("b2b busy after", {31'b0, bus.busy}, 32'd0);

        // funct3[2]=1 is not a multiply.
        @(negedge clk);
        bus.start_mul = 1'b1;
        bus.funct3    = 3'b100;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (bus.stall || bus.busy || bus.mul_done) pulses++;
            @(negedge clk);
        end
        check("funct3=100 ignored", pulses, 32'd0);
        bus.start_mul = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
